fmul_pipe_sched: RTL

- Round-robin scheduler and pipeline controller that shares one pipelined single-precision multiplier among N_REQ requesters.
- Arbitrates requests and registers the winning operands into stage 0.
- Drives the enables of the two inter-stage registers (multiply/add and add/normalize), tracks valid bits and requester IDs alongside the datapath, and captures results into an output register with valid/ready backpressure.
- Sits between the requesting units and the multiplier datapath.

---
 rtl/fmul_pipe_sched.sv | 118 +++++++++++
 1 files changed

// File: rtl/fmul_pipe_sched.sv
// Round-robin front end and stage controller for a shared 4-stage single-precision multiplier.
// Tracks valid bits and requester IDs alongside the external datapath registers.
module fmul_pipe_sched #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic                  flush,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [32*N_REQ-1:0]   req_a,
  input  logic [32*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]      req_ready,
  output logic [31:0]           dp_a,
  output logic [31:0]           dp_b,
  output logic                  en_s1,
  output logic                  en_s2,
  input  logic [31:0]           dp_q,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [31:0]           res_q,
  output logic [ID_W-1:0]       res_id,
  output logic [2:0]            inflight
);

  // Handshakes: a requester transfers on req_valid & req_ready, the consumer on
  // res_valid & res_ready; ready never waits for valid except to pick the winner.

  logic            v0, v1, v2;
  logic [ID_W-1:0] id0, id1, id2;
  logic [ID_W-1:0] ptr;
  logic            adv0, adv3;
  logic            gnt_any;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W-1:0] ptr_next;
  logic            v0_n, v1_n, v2_n, rv_n;
  logic [2:0]      inflight_n;

  // Each stage may move when the one below it moves or is empty.
  assign adv3  = ~res_valid | res_ready;
  assign en_s2 = ~v2 | adv3;
  assign en_s1 = ~v1 | en_s2;
  assign adv0  = ~v0 | en_s1;

  always_comb begin
    int idx;
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    req_ready = '0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = ID_W'(idx);
      end
    end
    if (!adv0 || flush) gnt_any = 1'b0;
    if (gnt_any) req_ready[gnt_idx] = 1'b1;
  end

  assign ptr_next = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);

  always_comb begin
    v0_n = 1'b0;
    v1_n = 1'b0;
    v2_n = 1'b0;
    rv_n = 1'b0;
    if (!flush) begin
      v0_n = adv0  ? gnt_any : v0;
      v1_n = en_s1 ? v0      : v1;
      v2_n = en_s2 ? v1      : v2;
      rv_n = adv3  ? v2      : res_valid;
    end
    inflight_n = 3'(v0_n) + 3'(v1_n) + 3'(v2_n) + 3'(rv_n);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      v0        <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      res_valid <= 1'b0;
      id0       <= '0;
      id1       <= '0;
      id2       <= '0;
      ptr       <= '0;
      dp_a      <= '0;
      dp_b      <= '0;
      res_q     <= '0;
      res_id    <= '0;
      inflight  <= '0;
    end else begin
      v0        <= v0_n;
      v1        <= v1_n;
      v2        <= v2_n;
      res_valid <= rv_n;
      inflight  <= inflight_n;
      if (gnt_any) begin
        dp_a <= req_a[32*int'(gnt_idx) +: 32];
        dp_b <= req_b[32*int'(gnt_idx) +: 32];
        id0  <= gnt_idx;
        ptr  <= ptr_next;
      end
      // IDs ride with the data; flushed stages are dead so their IDs are don't-care.
      if (!flush) begin
        if (en_s1) id1 <= id0;
        if (en_s2) id2 <= id1;
        if (adv3 && v2) begin
          res_q  <= dp_q;
          res_id <= id2;
        end
      end
    end
  end

endmodule
